cpu_fetch_sequencer: RTL and testbench

- Multicycle instruction fetch and next-PC sequencer for the LEGv8 core; the producer end of the opcode interface that the control decoder consumes.
- Requests 32-bit instruction words from instruction memory and presents each instruction and its inst[31:21] field to the control decoder and datapath.
- Consumes the decoder's Branch/BranchZero/BranchNonZero outputs plus the ALU zero flag to compute the next PC.
- Stops on HALT, and raises a fault if instruction memory does not respond in time.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cpu_next_pc.sv | 39 +++
 rtl/cpu_fetch_sequencer.sv | 111 +++++++++++
 tb/tb_cpu_fetch_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the LEGv8 fetch sequencer
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [10:0] OPC_HALT = 11'b11111111111;

   localparam int IMM26_MSB = 25;
   localparam int IMM26_LSB = 0;
   localparam int IMM19_MSB = 23;
   localparam int IMM19_LSB = 5;

   localparam int PC_INC = 4;

endpackage

// File: rtl/cpu_next_pc.sv
// rtl/cpu_next_pc.sv - branch target computation and next-PC priority mux
module cpu_next_pc
   import cpu_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic [PC_W-1:0] pc,
   input  logic [31:0]     inst,
   input  logic            branch,
   input  logic            branch_zero,
   input  logic            branch_nonzero,
   input  logic            alu_zero,
   output logic [PC_W-1:0] next_pc
);

   localparam int W26 = IMM26_MSB - IMM26_LSB + 1;
   localparam int W19 = IMM19_MSB - IMM19_LSB + 1;

   logic [PC_W-1:0] off26;
   logic [PC_W-1:0] off19;
   logic            unused_opcode;

   // Offsets are word counts: sign-extend to full width, then scale to bytes.
   assign off26 = {{(PC_W-W26){inst[IMM26_MSB]}}, inst[IMM26_MSB:IMM26_LSB]} << 2;
   assign off19 = {{(PC_W-W19){inst[IMM19_MSB]}}, inst[IMM19_MSB:IMM19_LSB]} << 2;

   assign unused_opcode = ^inst[31:26];

   always_comb begin
      next_pc = pc + PC_W'(PC_INC);
      if (branch)
         next_pc = pc + off26;
      else if (branch_zero && alu_zero)
         next_pc = pc + off19;
      else if (branch_nonzero && !alu_zero)
         next_pc = pc + off19;
   end

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// rtl/cpu_fetch_sequencer.sv - multicycle instruction fetch and next-PC sequencer
module cpu_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int          PC_W        = 64,
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst,
   output logic [10:0]     inst31_21,
   output logic            inst_valid,
   input  logic            inst_done,
   input  logic            branch,
   input  logic            branch_zero,
   input  logic            branch_nonzero,
   input  logic            alu_zero,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     retired,
   output logic            halted,
   output logic            fault
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t          state;
   logic [7:0]      wait_cnt;
   logic            req_q;
   logic [PC_W-1:0] next_pc;

   cpu_next_pc #(.PC_W(PC_W)) u_next_pc (
      .pc             (pc),
      .inst           (inst),
      .branch         (branch),
      .branch_zero    (branch_zero),
      .branch_nonzero (branch_nonzero),
      .alu_zero       (alu_zero),
      .next_pc        (next_pc)
   );

   assign imem_req  = req_q;
   assign imem_addr = pc;
   assign inst31_21 = inst[31:21];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC[PC_W-1:0];
         req_q      <= 1'b0;
         inst       <= 32'h0;
         inst_valid <= 1'b0;
         retired    <= 32'h0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         wait_cnt   <= 8'h0;
      end else begin
         case (state)
            S_FETCH: begin
               req_q <= 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_ack) begin
                  inst       <= imem_rdata;
                  inst_valid <= 1'b1;
                  req_q      <= 1'b0;
                  wait_cnt   <= 8'h0;
                  state      <= S_ISSUE;
               end else if (wait_cnt == TMO_LAST) begin
                  req_q <= 1'b0;
                  fault <= 1'b1;
                  state <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 8'h1;
               end
            end
            S_ISSUE: begin
               // HALT is recognised from the opcode alone; it never retires.
               if (inst[31:21] == OPC_HALT) begin
                  inst_valid <= 1'b0;
                  halted     <= 1'b1;
                  state      <= S_HALT;
               end else if (inst_done) begin
                  pc         <= next_pc;
                  retired    <= retired + 32'h1;
                  inst_valid <= 1'b0;
                  state      <= S_FETCH;
               end
            end
            S_HALT: begin
               req_q      <= 1'b0;
               inst_valid <= 1'b0;
            end
            S_FAULT: begin
               req_q      <= 1'b0;
               inst_valid <= 1'b0;
            end
            default: begin
               req_q <= 1'b0;
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// tb/tb_cpu_fetch_sequencer.sv - randomized self-checking bench for cpu_fetch_sequencer
module tb_cpu_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst;
   logic [10:0] inst31_21;
   logic        inst_valid;
   logic        inst_done = 1'b0;
   logic        branch = 1'b0;
   logic        branch_zero = 1'b0;
   logic        branch_nonzero = 1'b0;
   logic        alu_zero = 1'b0;
   logic [63:0] pc;
   logic [31:0] retired;
   logic        halted;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] cur_word = 32'h8B020020;
   logic        mem_en = 1'b1;
   int          max_wait = 0;
   int          wait_left = 0;
   logic        force_ack = 1'b0;
   logic [31:0] force_data = 32'h0;
   logic [63:0] ack_addr = 64'h0;

   logic [63:0] m_pc = 64'h0;
   logic [31:0] m_ret = 32'h0;

   cpu_fetch_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst           (inst),
      .inst31_21      (inst31_21),
      .inst_valid     (inst_valid),
      .inst_done      (inst_done),
      .branch         (branch),
      .branch_zero    (branch_zero),
      .branch_nonzero (branch_nonzero),
      .alu_zero       (alu_zero),
      .pc             (pc),
      .retired        (retired),
      .halted         (halted),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // Memory responder: acks a pending request after a random number of cycles.
   initial begin
      forever begin
         @(negedge clk);
         imem_ack = 1'b0;
         if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = force_data;
         end else if (mem_en && imem_req) begin
            if (wait_left == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = cur_word;
               ack_addr   = imem_addr;
               wait_left  = $urandom_range(max_wait, 0);
            end else begin
               wait_left--;
            end
         end
      end
   end

   function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] w,
                                              input logic b, input logic bz, input logic bnz,
                                              input logic az);
      longint off26;
      longint off19;
      off26 = longint'(w[25:0]);
      if (w[25]) off26 = off26 - 64'sd67108864;
      off19 = longint'(w[23:5]);
      if (w[23]) off19 = off19 - 64'sd524288;
      if (b)              return p + 64'(off26 * 4);
      else if (bz && az)  return p + 64'(off19 * 4);
      else if (bnz && !az) return p + 64'(off19 * 4);
      else                return p + 64'd4;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      inst_done = 1'b0;
      force_ack = 1'b0;
      wait_left = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_pc  = 64'h0;
      m_ret = 32'h0;
   endtask

   // Wait for the current instruction to issue, check it, then complete it.
   task automatic run_inst(input logic [31:0] w, input logic b, input logic bz,
                           input logic bnz, input logic az, input int done_dly);
      int n;
      cur_word = w;
      n = 0;
      while (inst_valid !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (inst_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL issue_timeout: inst_valid=%b required 1", inst_valid);
         return;
      end
      n_cmp++;
      if (inst !== w || inst31_21 !== w[31:21] || ack_addr !== m_pc || pc !== m_pc) begin
         n_bad++;
         $display("FAIL issue_state: inst=%h op=%h addr=%h pc=%h required inst=%h op=%h pc=%h",
                  inst, inst31_21, ack_addr, pc, w, w[31:21], m_pc);
      end
      repeat (done_dly) @(negedge clk);
      branch = b; branch_zero = bz; branch_nonzero = bnz; alu_zero = az;
      inst_done = 1'b1;
      @(posedge clk);
      #1;
      inst_done = 1'b0;
      m_pc  = model_next(m_pc, w, b, bz, bnz, az);
      m_ret = m_ret + 32'd1;
      @(negedge clk);
      n_cmp++;
      if (pc !== m_pc || retired !== m_ret || inst_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL retire: pc=%h retired=%0d valid=%b required pc=%h retired=%0d valid=0",
                  pc, retired, inst_valid, m_pc, m_ret);
      end
   endtask

   task automatic test_reset();
      mem_en = 1'b1;
      max_wait = 0;
      cur_word = 32'h8B020020;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (imem_req !== 1'b0 || inst !== 32'h0 || inst_valid !== 1'b0 || pc !== 64'h0 ||
          retired !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: req=%b inst=%h valid=%b pc=%h ret=%0d h=%b f=%b required all zero",
                  imem_req, inst, inst_valid, pc, retired, halted, fault);
      end
      do_reset();
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_cycle: imem_req=%b required 0", imem_req);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         n_bad++;
         $display("FAIL first_req: req=%b addr=%h required 1 / 0", imem_req, imem_addr);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst31_21 !== 11'h458 || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL first_issue: valid=%b op=%h req=%b required 1 / 458 / 0",
                  inst_valid, inst31_21, imem_req);
      end
   endtask

   task automatic test_directed();
      max_wait = 2;
      run_inst(32'h8B020020, 0, 0, 0, 0, 0);
      run_inst(32'h8B020020, 0, 0, 0, 0, 1);
      run_inst(32'h8B020020, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pc !== 64'hC) begin
         n_bad++;
         $display("FAIL add_pc: pc=%h required c", pc);
      end
      run_inst(32'h8B020020, 0, 0, 0, 0, 0);
      run_inst(32'h17FFFFFF, 1, 0, 0, 0, 0);
      n_cmp++;
      if (pc !== 64'hC) begin
         n_bad++;
         $display("FAIL b_back: pc=%h required c", pc);
      end
      run_inst(32'h14000005, 1, 0, 0, 0, 0);
      run_inst(32'hB4000060, 0, 1, 0, 1, 0);
      n_cmp++;
      if (pc !== 64'h2C) begin
         n_bad++;
         $display("FAIL cbz_taken: pc=%h required 2c", pc);
      end
      run_inst(32'hB4000060, 0, 1, 0, 0, 0);
      n_cmp++;
      if (pc !== 64'h30) begin
         n_bad++;
         $display("FAIL cbz_not_taken: pc=%h required 30", pc);
      end
      run_inst(32'hB5000104, 1, 0, 1, 0, 0);
      run_inst(32'hB5000040, 0, 0, 1, 1, 0);
      run_inst(32'hB5FFFFE0, 1, 1, 1, 1, 2);
   endtask

   task automatic test_ack_outside_wait();
      int n;
      cur_word = 32'h8B020020;
      n = 0;
      while (inst_valid !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      force_data = 32'hDEADBEEF;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (inst !== 32'h8B020020 || inst_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL stray_ack: inst=%h valid=%b required 8b020020 / 1", inst, inst_valid);
      end
      run_inst(32'h8B020020, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] w;
      max_wait = 3;
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         if (w[31:21] == 11'h7FF) w[31] = 1'b0;
         run_inst(w, 1'($urandom_range(3, 0) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(2, 0));
      end
   endtask

   task automatic test_halt();
      int n;
      logic seen_req;
      cur_word = 32'hFFE00000;
      n = 0;
      while (inst_valid !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      inst_done = 1'b1;
      @(negedge clk);
      inst_done = 1'b0;
      n_cmp++;
      if (halted !== 1'b1 || inst_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_entry: halted=%b valid=%b required 1 / 0", halted, inst_valid);
      end
      seen_req = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (imem_req !== 1'b0) seen_req = 1'b1;
      end
      n_cmp++;
      if (seen_req || retired !== m_ret || pc !== m_pc) begin
         n_bad++;
         $display("FAIL halt_hold: req_seen=%b retired=%0d pc=%h required 0 / %0d / %h",
                  seen_req, retired, pc, m_ret, m_pc);
      end
   endtask

   task automatic test_timeout();
      int n;
      logic early;
      mem_en = 1'b0;
      do_reset();
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      early = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (fault !== 1'b0 || imem_req !== 1'b1) early = 1'b1;
      end
      n_cmp++;
      if (early) begin
         n_bad++;
         $display("FAIL timeout_early: fault or req dropped before 16 wait cycles, required hold");
      end
      @(negedge clk);
      n_cmp++;
      if (fault !== 1'b1 || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_fault: fault=%b req=%b required 1 / 0", fault, imem_req);
      end
      force_data = 32'h8B020020;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (fault !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL late_ack: fault=%b valid=%b inst=%h req=%b required 1 / 0 / 0 / 0",
                  fault, inst_valid, inst, imem_req);
      end
   endtask

   task automatic test_reset_mid_wait();
      mem_en = 1'b1;
      max_wait = 0;
      do_reset();
      run_inst(32'h14000010, 1, 0, 0, 0, 0);
      mem_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (imem_req !== 1'b0 || pc !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_mid_wait: req=%b pc=%h required 0 / 0", imem_req, pc);
      end
      mem_en = 1'b1;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ack_outside_wait();
      test_random();
      test_halt();
      test_timeout();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

endmodule
